// File: rtl/spi_byte_engine_if.sv
// Byte-level command/response bundle for spi_byte_engine.
// master drives start/tx_byte/crc_en_in/cs_req; slave returns busy/done/rx_byte.
interface spi_byte_engine_if;
    logic       start;
    logic [7:0] tx_byte;
    logic       crc_en_in;
    logic       cs_req;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;

    modport master (
        output start, tx_byte, crc_en_in, cs_req,
        input  busy, done, rx_byte
    );

    modport slave (
        input  start, tx_byte, crc_en_in, cs_req,
        output busy, done, rx_byte
    );
endinterface

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter, MSB first, spi_clk derived from clk by CLK_DIV.
// Ports: clk, reset_n, bus (byte cmd/resp), miso, spi_clk, mosi, cs_n, crc_en.
module spi_byte_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_byte_engine_if.slave  bus,
    input  logic              miso,
    output logic              spi_clk,
    output logic              mosi,
    output logic              cs_n,
    output logic              crc_en
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    state_t     state_d;
    logic [7:0] div_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rx_q;
    logic       mosi_q;
    logic       cs_n_q;
    logic       crc_q;
    logic       half_end;
    logic       busy_w;

    assign half_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (bus.start) state_d = LOW;
            LOW:  if (half_end)  state_d = HIGH;
            HIGH: if (half_end)
                      state_d = (bit_cnt == 4'd7) ? DONE : LOW;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            rx_q    <= '0;
            mosi_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            crc_q   <= 1'b0;
        end else begin
            // Sampling in DONE lets a request changed mid-byte
            // show up on the very first IDLE cycle.
            if (state == IDLE || state == DONE)
                cs_n_q <= ~bus.cs_req;
            unique case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (bus.start) begin
                        shreg   <= bus.tx_byte;
                        crc_q   <= bus.crc_en_in;
                        bit_cnt <= '0;
                        mosi_q  <= bus.tx_byte[7];
                    end
                end
                LOW: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        shreg   <= {shreg[6:0], miso};
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        // shreg already shifted on the rising
                        // edge, so [7] is the next bit out.
                        if (bit_cnt == 4'd7) begin
                            rx_q   <= shreg;
                            mosi_q <= 1'b1;
                        end else begin
                            mosi_q <= shreg[7];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: mosi_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy_w      = (state == LOW) || (state == HIGH);
    assign bus.busy    = busy_w;
    assign bus.done    = (state == DONE);
    assign bus.rx_byte = rx_q;
    assign spi_clk     = (state == HIGH);
    assign mosi        = mosi_q;
    assign cs_n        = cs_n_q;
    assign crc_en      = busy_w & crc_q;

endmodule
